// File: rtl/react_keyscan.sv
// 4x4 matrix keypad scanner: one active-low column driven per scan tick, debounced
// press/release detection, and a one-clock key_valid pulse per accepted key.

module react_keyscan_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] COL,
  input logic       key_valid,
  input logic       key_down
);

  a_col_one_low: assert property (@(posedge clk) disable iff (!rst) $onehot(~COL));
  a_valid_single: assert property (@(posedge clk) disable iff (!rst) key_valid |=> !key_valid);
  a_valid_with_down: assert property (@(posedge clk) disable iff (!rst) key_valid |-> key_down);

endmodule

module react_keyscan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [7:0]       DEB_N    = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       rel_q, rel_d;
  logic [3:0]       col_out_q;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;

  function automatic logic [1:0] lowest_low(input logic [3:0] row_v);
    logic [1:0] idx;
    if (!row_v[0]) begin
      idx = 2'd0;
    end else if (!row_v[1]) begin
      idx = 2'd1;
    end else if (!row_v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

  // Row lines idle high through the pull-ups, so the synchronizer resets to ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= ROW;
      row_sync_q <= row_meta_q;
    end
  end

  assign tick_s = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (tick_s) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

  // All decisions happen on tick edges; between ticks every register holds.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (row_sync_q != 4'hF) begin
            row_d   = lowest_low(row_sync_q);
            cnt_d   = 8'd1;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!row_sync_q[row_q]) begin
            if ((cnt_q + 8'd1) == DEB_N) begin
              state_d     = HELD;
              cnt_d       = 8'd0;
              rel_d       = 8'd0;
              key_code_d  = {col_q, row_q};
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            state_d = SCAN;
            cnt_d   = 8'd0;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          if (row_sync_q[row_q]) begin
            if ((rel_q + 8'd1) == DEB_N) begin
              state_d    = SCAN;
              rel_d      = 8'd0;
              key_down_d = 1'b0;
              col_d      = col_q + 2'd1;
            end else begin
              rel_d = rel_q + 8'd1;
            end
          end else begin
            rel_d = 8'd0;
          end
        end
        default: begin
          state_d    = SCAN;
          col_d      = 2'd0;
          cnt_d      = 8'd0;
          rel_d      = 8'd0;
          key_down_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // COL is driven from the next column index so it changes on the same edge as col_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= 8'd0;
      rel_q       <= 8'd0;
      col_out_q   <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      col_out_q   <= col_drive(col_d);
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign COL       = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

  react_keyscan_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .COL       (COL),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

endmodule
